ram_arbiter: RTL and testbench

- Shares the single-port program/data RAM between two requesters: the CPU core (cpu_*) and the host loader/debug port (ldr_*).
- Issues at most one RAM access per cycle, returns read data to the requester that issued it, and tags each read by owner.
- When both requesters are active, grants alternate round-robin. The loader can lock the RAM for bulk program load.
- Sits between the core/loader and the RAM megafunction: address_ram, data_ram and q_ram connect straight through.

---
 rtl/ram_arb_pkg.sv | 17 +
 rtl/ram_arbiter_if.sv | 49 ++++
 rtl/rd_return_pipe.sv | 67 ++++++
 rtl/ram_arbiter.sv | 149 ++++++++++++++
 tb/tb_ram_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the RAM arbiter (ram_arbiter and its sub-module).
package ram_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LDR = 1'b1
    } owner_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester and RAM-side bus of the RAM arbiter.
// slave: the arbiter; master: the CPU/loader/RAM environment.
interface ram_arbiter_if #(
    parameter int unsigned ADDR_W = ram_arb_pkg::ADDR_W_DEF,
    parameter int unsigned DATA_W = ram_arb_pkg::DATA_W_DEF
) ();

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              ldr_req;
    logic              ldr_we;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic              ldr_gnt;
    logic              ldr_rvalid;
    logic [DATA_W-1:0] ldr_rdata;
    logic              ldr_lock;
    logic              locked;

    logic [ADDR_W-1:0] address_ram;
    logic [DATA_W-1:0] data_ram;
    logic              wren_ram;
    logic [DATA_W-1:0] q_ram;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
        output ldr_gnt, ldr_rvalid, ldr_rdata, locked,
        output address_ram, data_ram, wren_ram,
        input  q_ram
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
        input  ldr_gnt, ldr_rvalid, ldr_rdata, locked,
        input  address_ram, data_ram, wren_ram,
        output q_ram
    );

endinterface

// File: rtl/rd_return_pipe.sv
// Read-return pipeline: RD_LAT-deep {valid, owner} shift register that lines up with
// q_ram, plus per-requester rdata steering and hold registers.
module rd_return_pipe
    import ram_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_issue,
    input  owner_t            i_owner,
    input  logic [DATA_W-1:0] i_q_ram,
    output logic              o_cpu_rvalid,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_ldr_rvalid,
    output logic [DATA_W-1:0] o_ldr_rdata
);

    logic [RD_LAT-1:0] r_vld;
    logic [RD_LAT-1:0] r_own;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_ldr_rdata;
    logic              w_cpu_hit;
    logic              w_ldr_hit;

    // Shift issued reads toward the stage that coincides with valid q_ram.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_vld <= '0;
            r_own <= '0;
        end else begin
            r_vld[0] <= i_issue;
            r_own[0] <= (i_owner == OWN_LDR);
            for (int i = 1; i < int'(RD_LAT); i++) begin
                r_vld[i] <= r_vld[i-1];
                r_own[i] <= r_own[i-1];
            end
        end
    end

    // Decode the pipeline tail into per-owner hits.
    always_comb begin
        w_cpu_hit = r_vld[RD_LAT-1] && !r_own[RD_LAT-1];
        w_ldr_hit = r_vld[RD_LAT-1] &&  r_own[RD_LAT-1];
    end

    // Capture returned data so the non-owner side keeps its last value.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cpu_rdata <= '0;
            r_ldr_rdata <= '0;
        end else begin
            if (w_cpu_hit) r_cpu_rdata <= i_q_ram;
            if (w_ldr_hit) r_ldr_rdata <= i_q_ram;
        end
    end

    // Present q_ram directly in the return cycle, otherwise the held value.
    always_comb begin
        o_cpu_rvalid = w_cpu_hit;
        o_ldr_rvalid = w_ldr_hit;
        o_cpu_rdata  = w_cpu_hit ? i_q_ram : r_cpu_rdata;
        o_ldr_rdata  = w_ldr_hit ? i_q_ram : r_ldr_rdata;
    end

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter between CPU core and host loader: round-robin under contention,
// loader lock for bulk load, owner-tagged read return.
// Optional debug dump ports are built when RAM_ARBITER_DEBUG_EN is defined.
// The attached RAM must use new-data read-during-write mode.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned RD_LAT = 1
) (
    input  logic         clock,
    input  logic         reset_n,
    ram_arbiter_if.slave bus
`ifdef RAM_ARBITER_DEBUG_EN
    ,
    output logic [1:0]   dbg_owner,
    output logic [15:0]  dbg_state,
    output logic [15:0]  dbg_cpu_wait,
    output logic [15:0]  dbg_ldr_cnt
`endif
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    owner_t            r_last_owner;
    owner_t            w_last_owner_nxt;
    logic              w_cpu_gnt;
    logic              w_ldr_gnt;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_wren;
    logic              w_rd_issue;
    owner_t            w_rd_owner;

    // State and round-robin history registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= UNLOCKED;
            r_last_owner <= OWN_CPU;
        end else begin
            r_state      <= w_state_nxt;
            r_last_owner <= w_last_owner_nxt;
        end
    end

    // Next state: lock on a locking loader grant, unlock whenever ldr_lock drops.
    always_comb begin
        w_state_nxt      = r_state;
        w_last_owner_nxt = r_last_owner;
        if (w_cpu_gnt) w_last_owner_nxt = OWN_CPU;
        if (w_ldr_gnt) w_last_owner_nxt = OWN_LDR;
        case (r_state)
            UNLOCKED: if (w_ldr_gnt && bus.ldr_lock) w_state_nxt = LOCKED;
            LOCKED:   if (!bus.ldr_lock) w_state_nxt = UNLOCKED;
            default:  w_state_nxt = UNLOCKED;
        endcase
    end

    // Grant decode; both grants are held low while reset is asserted.
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_ldr_gnt = 1'b0;
        if (reset_n) begin
            case (r_state)
                LOCKED: w_ldr_gnt = bus.ldr_req;
                default: begin
                    if (bus.cpu_req && bus.ldr_req) begin
                        w_ldr_gnt = (r_last_owner == OWN_CPU);
                        w_cpu_gnt = (r_last_owner == OWN_LDR);
                    end else begin
                        w_cpu_gnt = bus.cpu_req;
                        w_ldr_gnt = bus.ldr_req;
                    end
                end
            endcase
        end
    end

    // RAM mux: granted requester drives the RAM, idle bus is all zero.
    always_comb begin
        w_addr     = '0;
        w_data     = '0;
        w_wren     = 1'b0;
        w_rd_issue = 1'b0;
        w_rd_owner = OWN_CPU;
        if (w_cpu_gnt) begin
            w_addr     = bus.cpu_addr;
            w_data     = bus.cpu_wdata;
            w_wren     = bus.cpu_we;
            w_rd_issue = !bus.cpu_we;
        end else if (w_ldr_gnt) begin
            w_addr     = bus.ldr_addr;
            w_data     = bus.ldr_wdata;
            w_wren     = bus.ldr_we;
            w_rd_issue = !bus.ldr_we;
            w_rd_owner = OWN_LDR;
        end
    end

    assign bus.cpu_gnt     = w_cpu_gnt;
    assign bus.ldr_gnt     = w_ldr_gnt;
    assign bus.address_ram = w_addr;
    assign bus.data_ram    = w_data;
    assign bus.wren_ram    = w_wren;
    assign bus.locked      = (r_state == LOCKED);

    rd_return_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_return_pipe (
        .i_clock      (clock),
        .i_reset_n    (reset_n),
        .i_issue      (w_rd_issue),
        .i_owner      (w_rd_owner),
        .i_q_ram      (bus.q_ram),
        .o_cpu_rvalid (bus.cpu_rvalid),
        .o_cpu_rdata  (bus.cpu_rdata),
        .o_ldr_rvalid (bus.ldr_rvalid),
        .o_ldr_rdata  (bus.ldr_rdata)
    );

`ifdef RAM_ARBITER_DEBUG_EN
    logic [1:0]  r_dbg_owner;
    logic [15:0] r_dbg_cpu_wait;
    logic [15:0] r_dbg_ldr_cnt;

    // Debug dump: last-cycle grants, saturating CPU stall count, loader grant count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dbg_owner    <= '0;
            r_dbg_cpu_wait <= '0;
            r_dbg_ldr_cnt  <= '0;
        end else begin
            r_dbg_owner <= {w_ldr_gnt, w_cpu_gnt};
            if (bus.cpu_req && !w_cpu_gnt && (r_dbg_cpu_wait != 16'hFFFF)) begin
                r_dbg_cpu_wait <= r_dbg_cpu_wait + 16'd1;
            end
            if (w_ldr_gnt) r_dbg_ldr_cnt <= r_dbg_ldr_cnt + 16'd1;
        end
    end

    assign dbg_owner    = r_dbg_owner;
    assign dbg_state    = {15'd0, r_state};
    assign dbg_cpu_wait = r_dbg_cpu_wait;
    assign dbg_ldr_cnt  = r_dbg_ldr_cnt;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomised scoreboard bench for ram_arbiter with a behavioural RAM and reference model.
// Covers debug ports too when RAM_ARBITER_DEBUG_EN is defined.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    localparam int unsigned RD_LAT = 2;

    typedef struct {
        bit        idle;
        bit        we;
        bit [15:0] addr;
        bit [15:0] data;
        bit        lock;
    } item_t;

    typedef struct {
        bit          own_ldr;
        logic [15:0] data;
        int unsigned due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    item_t cpu_q[$];
    item_t ldr_q[$];
    exp_t  exp_q[$];

    logic [15:0] ram [0:65535];
    logic [15:0] model_mem [0:65535];
    logic [15:0] q1 = '0;
    logic [15:0] q2 = '0;

    ram_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

`ifdef RAM_ARBITER_DEBUG_EN
    logic [1:0]  dbg_owner;
    logic [15:0] dbg_state;
    logic [15:0] dbg_cpu_wait;
    logic [15:0] dbg_ldr_cnt;
`endif

    ram_arbiter #(
        .ADDR_W (16),
        .DATA_W (16),
        .RD_LAT (RD_LAT)
    ) dut (
        .clock        (clk),
        .reset_n      (rst_n),
        .bus          (bus)
`ifdef RAM_ARBITER_DEBUG_EN
        ,
        .dbg_owner    (dbg_owner),
        .dbg_state    (dbg_state),
        .dbg_cpu_wait (dbg_cpu_wait),
        .dbg_ldr_cnt  (dbg_ldr_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural synchronous RAM, new-data read-during-write, RD_LAT read latency.
    always @(posedge clk) begin
        if (bus.wren_ram) ram[bus.address_ram] <= bus.data_ram;
        q1 <= bus.wren_ram ? bus.data_ram : ram[bus.address_ram];
        q2 <= q1;
    end
    assign bus.q_ram = (RD_LAT == 1) ? q1 : q2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic item_t mk(bit idle, bit we, bit [15:0] a, bit [15:0] d, bit lock);
        item_t it;
        it.idle = idle; it.we = we; it.addr = a; it.data = d; it.lock = lock;
        return it;
    endfunction

    // Reference model state.
    bit          m_locked = 1'b0;
    bit          m_last_ldr = 1'b0;
    logic [15:0] m_last_cpu_rd = '0;
    logic [15:0] m_last_ldr_rd = '0;
`ifdef RAM_ARBITER_DEBUG_EN
    logic [15:0] m_wait = '0;
    logic [15:0] m_lcnt = '0;
    logic [1:0]  m_own = '0;
`endif

    // Reference model: predict grants/RAM bus, push expected read responses.
    always @(negedge clk) begin
        bit          cr, lr, eg_c, eg_l;
        logic [15:0] ea, ed;
        bit          ew;
        exp_t        e;
        if (!rst_n) begin
            chk("rst_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
            chk("rst_ldr_gnt", 32'(bus.ldr_gnt), 32'd0);
            chk("rst_wren", 32'(bus.wren_ram), 32'd0);
            chk("rst_addr", 32'(bus.address_ram), 32'd0);
            chk("rst_data", 32'(bus.data_ram), 32'd0);
            chk("rst_locked", 32'(bus.locked), 32'd0);
            m_locked = 1'b0;
            m_last_ldr = 1'b0;
`ifdef RAM_ARBITER_DEBUG_EN
            m_wait = '0; m_lcnt = '0; m_own = '0;
            chk("rst_dbg_wait", 32'(dbg_cpu_wait), 32'd0);
`endif
        end else begin
            cr = bus.cpu_req;
            lr = bus.ldr_req;
            if (m_locked) begin
                eg_c = 1'b0; eg_l = lr;
            end else if (cr && lr) begin
                eg_l = !m_last_ldr; eg_c = m_last_ldr;
            end else begin
                eg_c = cr; eg_l = lr;
            end
            chk("cpu_gnt", 32'(bus.cpu_gnt), 32'(eg_c));
            chk("ldr_gnt", 32'(bus.ldr_gnt), 32'(eg_l));
            chk("locked", 32'(bus.locked), 32'(m_locked));
`ifdef RAM_ARBITER_DEBUG_EN
            chk("dbg_cpu_wait", 32'(dbg_cpu_wait), 32'(m_wait));
            chk("dbg_ldr_cnt", 32'(dbg_ldr_cnt), 32'(m_lcnt));
            chk("dbg_owner", 32'(dbg_owner), 32'(m_own));
            chk("dbg_state", 32'(dbg_state), m_locked ? 32'(LOCKED) : 32'(UNLOCKED));
            if (cr && !eg_c && m_wait != 16'hFFFF) m_wait = m_wait + 16'd1;
            if (eg_l) m_lcnt = m_lcnt + 16'd1;
            m_own = {eg_l, eg_c};
`endif
            ea = '0; ed = '0; ew = 1'b0;
            if (eg_c) begin
                ea = bus.cpu_addr; ed = bus.cpu_wdata; ew = bus.cpu_we;
            end else if (eg_l) begin
                ea = bus.ldr_addr; ed = bus.ldr_wdata; ew = bus.ldr_we;
            end
            chk("address_ram", 32'(bus.address_ram), 32'(ea));
            chk("data_ram", 32'(bus.data_ram), 32'(ed));
            chk("wren_ram", 32'(bus.wren_ram), 32'(ew));
            if (eg_c || eg_l) begin
                if (ew) begin
                    model_mem[ea] = ed;
                end else begin
                    e.own_ldr = eg_l; e.data = model_mem[ea]; e.due = cyc + RD_LAT;
                    exp_q.push_back(e);
                end
                m_last_ldr = eg_l;
            end
            if (m_locked) m_locked = bus.ldr_lock;
            else if (eg_l && bus.ldr_lock) m_locked = 1'b1;
        end
    end

    // Monitor: pop the scoreboard when a response is due and compare the return ports.
    always @(negedge clk) begin
        bit   e_cv, e_lv;
        exp_t e;
        if (!rst_n) begin
            chk("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
            chk("rst_ldr_rvalid", 32'(bus.ldr_rvalid), 32'd0);
            chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
            chk("rst_ldr_rdata", 32'(bus.ldr_rdata), 32'd0);
            exp_q.delete();
            m_last_cpu_rd = '0;
            m_last_ldr_rd = '0;
        end else begin
            e_cv = 1'b0; e_lv = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                if (e.own_ldr) begin
                    e_lv = 1'b1; m_last_ldr_rd = e.data;
                end else begin
                    e_cv = 1'b1; m_last_cpu_rd = e.data;
                end
            end
            chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(e_cv));
            chk("ldr_rvalid", 32'(bus.ldr_rvalid), 32'(e_lv));
            chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(m_last_cpu_rd));
            chk("ldr_rdata", 32'(bus.ldr_rdata), 32'(m_last_ldr_rd));
        end
    end

    // Requester driver: hold each request until its grant is seen, then take the next item.
    initial begin
        bit    gc, gl;
        item_t it;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.ldr_req = 0; bus.ldr_we = 0; bus.ldr_addr = '0; bus.ldr_wdata = '0;
        bus.ldr_lock = 0;
        forever begin
            @(negedge clk);
            gc = bus.cpu_gnt;
            gl = bus.ldr_gnt;
            @(posedge clk);
            #1;
            if (!bus.cpu_req || gc) begin
                bus.cpu_req = 1'b0;
                if (cpu_q.size() > 0) begin
                    it = cpu_q.pop_front();
                    if (!it.idle) begin
                        bus.cpu_req = 1'b1; bus.cpu_we = it.we;
                        bus.cpu_addr = it.addr; bus.cpu_wdata = it.data;
                    end
                end
            end
            if (!bus.ldr_req || gl) begin
                bus.ldr_req = 1'b0;
                bus.ldr_lock = 1'b0;
                if (ldr_q.size() > 0) begin
                    it = ldr_q.pop_front();
                    bus.ldr_lock = it.lock;
                    if (!it.idle) begin
                        bus.ldr_req = 1'b1; bus.ldr_we = it.we;
                        bus.ldr_addr = it.addr; bus.ldr_wdata = it.data;
                    end
                end
            end
        end
    end

    task automatic drain();
        int n = 0;
        while ((cpu_q.size() > 0 || ldr_q.size() > 0 || bus.cpu_req || bus.ldr_req)
               && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (RD_LAT + 3) @(negedge clk);
        chk("drained_requests", 32'(n < 5000), 32'd1);
        chk("no_lost_responses", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_reset(input int unsigned len);
        @(posedge clk); #2 rst_n = 1'b0;
        repeat (len) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i] = '0;
            model_mem[i] = '0;
        end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // CPU-only read of a loader-written word.
        ldr_q.push_back(mk(0, 1, 16'h0010, 16'h1234, 0));
        cpu_q.push_back(mk(1, 0, 0, 0, 0));
        cpu_q.push_back(mk(0, 0, 16'h0010, 0, 0));
        drain();

        // Read-after-write on consecutive grants.
        ldr_q.push_back(mk(0, 1, 16'h0005, 16'hBEEF, 0));
        cpu_q.push_back(mk(1, 0, 0, 0, 0));
        cpu_q.push_back(mk(0, 0, 16'h0005, 0, 0));
        drain();

        // Locked bulk load with a CPU read pending, then release.
        for (int i = 0; i < 4; i++) ldr_q.push_back(mk(0, 1, 16'(i), 16'hA000 + 16'(i), 1));
        ldr_q.push_back(mk(1, 0, 0, 0, 0));
        cpu_q.push_back(mk(1, 0, 0, 0, 0));
        cpu_q.push_back(mk(0, 0, 16'h0002, 0, 0));
        drain();

        // Continuous contention straight after reset.
        pulse_reset(2);
        for (int i = 0; i < 8; i++) begin
            cpu_q.push_back(mk(0, 0, 16'(i), 0, 0));
            ldr_q.push_back(mk(0, 0, 16'(i + 1), 0, 0));
        end
        drain();

        // Reset while reads are in flight.
        for (int i = 0; i < 6; i++) begin
            cpu_q.push_back(mk(0, 0, 16'(i), 0, 0));
            ldr_q.push_back(mk(0, 0, 16'h0010, 0, 0));
        end
        repeat (4) @(negedge clk);
        pulse_reset(2);
        drain();

        // Randomised mix with occasional locking.
        for (int i = 0; i < 400; i++) begin
            cpu_q.push_back(mk($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                               16'($urandom_range(0, 15)), 16'($urandom), 0));
            ldr_q.push_back(mk($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                               16'($urandom_range(0, 15)), 16'($urandom),
                               $urandom_range(0, 5) == 0));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
